cordic_engine: RTL

CORDIC_ENGINE -- requirements
Module: cordic_engine

---
 rtl/cordic_pkg.sv | 56 +++++
 rtl/cordic_stage.sv | 44 ++++
 rtl/cordic_engine.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: mode encodings plus elaboration-time generators
// for the arctangent table and the aggregate gain correction constant.
package cordic_pkg;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } cordic_mode_e;

  // Internal precision (fraction bits) of the constant generators.
  localparam int PREC = 60;

  // atan(1/n) by its alternating power series, scaled by 2^PREC.
  function automatic logic [63:0] atan_recip(input logic [63:0] n);
    logic [63:0] pw;
    logic [63:0] n2;
    logic [63:0] acc;
    acc = '0;
    pw  = (64'd1 << PREC) / n;
    n2  = n * n;
    for (int k = 0; k < 48; k++) begin
      if (k % 2 == 1) acc = acc - pw / 64'(2 * k + 1);
      else            acc = acc + pw / 64'(2 * k + 1);
      pw = pw / n2;
    end
    return acc;
  endfunction

  // A(i) = round(atan(2^-i) * 2^frac); atan(1) is built as atan(1/2) + atan(1/3).
  function automatic logic [63:0] cordic_atan(input int i, input int frac);
    logic [63:0] v;
    if (i == 0)       v = atan_recip(64'd2) + atan_recip(64'd3);
    else if (i <= 30) v = atan_recip(64'd1 << i);
    else if (i < PREC) v = 64'd1 << (PREC - i);
    else              v = '0;
    return (v + (64'd1 << (PREC - 1 - frac))) >> (PREC - frac);
  endfunction

  // K = round(prod 1/sqrt(1 + 2^-2i) * 2^frac), via K^2 then an integer square root.
  function automatic logic [63:0] cordic_gain(input int iter, input int frac);
    logic [63:0] k2;
    logic [63:0] r;
    logic [63:0] t;
    k2 = 64'd1 << PREC;
    for (int i = 0; i < iter && i < 31; i++) begin
      k2 = k2 - k2 / ((64'd1 << (2 * i)) + 64'd1);
    end
    r = '0;
    for (int b = 30; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= k2) r = t;
    end
    return (r + (64'd1 << (29 - frac))) >> (30 - frac);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// UNROLL chained combinational CORDIC micro-rotations starting at shift BASE.
// Pure combinational; registering and backpressure are handled by the caller.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 16,
  parameter int UNROLL = 2,
  parameter int BASE   = 0
) (
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] z,
  output logic signed [WIDTH-1:0] x_next,
  output logic signed [WIDTH-1:0] y_next,
  output logic signed [WIDTH-1:0] z_next
);

  logic signed [WIDTH-1:0] xs [UNROLL+1];
  logic signed [WIDTH-1:0] ys [UNROLL+1];
  logic signed [WIDTH-1:0] zs [UNROLL+1];

  assign xs[0] = x;
  assign ys[0] = y;
  assign zs[0] = z;

  for (genvar u = 0; u < UNROLL; u++) begin : g_rot
    localparam int SH = BASE + u;
    localparam logic signed [WIDTH-1:0] ANG = WIDTH'(cordic_atan(SH, FRAC));
    logic neg;

    // neg: rotate clockwise (vectoring with y >= 0, or rotation with z < 0).
    assign neg = (mode == MODE_VEC) ? !ys[u][WIDTH-1] : zs[u][WIDTH-1];
    assign xs[u+1] = neg ? xs[u] + (ys[u] >>> SH) : xs[u] - (ys[u] >>> SH);
    assign ys[u+1] = neg ? ys[u] - (xs[u] >>> SH) : ys[u] + (xs[u] >>> SH);
    assign zs[u+1] = neg ? zs[u] + ANG : zs[u] - ANG;
  end

  assign x_next = xs[UNROLL];
  assign y_next = ys[UNROLL];
  assign z_next = zs[UNROLL];

endmodule

// File: rtl/cordic_engine.sv
// Pipelined CORDIC (rotation/vectoring per sample), latency ITER/UNROLL+3 cycles.
// Whole pipeline freezes while out_valid && !out_ready; in_ready mirrors that enable.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 16,
  parameter int ITER   = 16,
  parameter int UNROLL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z
);

  localparam int NSTG = ITER / UNROLL;
  localparam logic [2*WIDTH-1:0] GAIN = (2*WIDTH)'(cordic_gain(ITER, FRAC));

  logic                    alive;
  logic                    en;
  logic [NSTG:0]           v_r;
  logic [NSTG:0]           m_r;
  logic signed [WIDTH-1:0] x_r [NSTG+1];
  logic signed [WIDTH-1:0] y_r [NSTG+1];
  logic signed [WIDTH-1:0] z_r [NSTG+1];
  logic signed [WIDTH-1:0] x_n [NSTG];
  logic signed [WIDTH-1:0] y_n [NSTG];
  logic signed [WIDTH-1:0] z_n [NSTG];
  logic                    g_v;
  logic                    g_m;
  logic [WIDTH-1:0]        g_x;
  logic [WIDTH-1:0]        g_y;
  logic [WIDTH-1:0]        g_z;
  logic [2*WIDTH-1:0]      px;
  logic [2*WIDTH-1:0]      py;

  assign en       = !out_valid || out_ready;
  // alive keeps in_ready low until the first edge after reset release.
  assign in_ready = alive && en;

  for (genvar s = 0; s < NSTG; s++) begin : g_stage
    cordic_stage #(
      .WIDTH  (WIDTH),
      .FRAC   (FRAC),
      .UNROLL (UNROLL),
      .BASE   (s * UNROLL)
    ) u_stage (
      .mode   (m_r[s]),
      .x      (x_r[s]),
      .y      (y_r[s]),
      .z      (z_r[s]),
      .x_next (x_n[s]),
      .y_next (y_n[s]),
      .z_next (z_n[s])
    );
  end

  // Full 2*WIDTH products of sign-extended operands; the low 2*WIDTH bits are exact.
  always_comb begin
    px = {{WIDTH{x_r[NSTG][WIDTH-1]}}, x_r[NSTG]} * GAIN;
    py = {{WIDTH{y_r[NSTG][WIDTH-1]}}, y_r[NSTG]} * GAIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
      v_r   <= '0;
      m_r   <= '0;
      for (int s = 0; s <= NSTG; s++) begin
        x_r[s] <= '0;
        y_r[s] <= '0;
        z_r[s] <= '0;
      end
      g_v       <= 1'b0;
      g_m       <= 1'b0;
      g_x       <= '0;
      g_y       <= '0;
      g_z       <= '0;
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else begin
      alive <= 1'b1;
      if (en) begin
        v_r[0] <= in_valid && in_ready;
        m_r[0] <= in_mode;
        x_r[0] <= in_x;
        y_r[0] <= in_y;
        z_r[0] <= in_z;
        for (int s = 0; s < NSTG; s++) begin
          v_r[s+1] <= v_r[s];
          m_r[s+1] <= m_r[s];
          x_r[s+1] <= x_n[s];
          y_r[s+1] <= y_n[s];
          z_r[s+1] <= z_n[s];
        end
        g_v       <= v_r[NSTG];
        g_m       <= m_r[NSTG];
        g_x       <= WIDTH'(px >> FRAC);
        g_y       <= WIDTH'(py >> FRAC);
        g_z       <= z_r[NSTG];
        out_valid <= g_v;
        out_mode  <= g_m;
        out_x     <= g_x;
        out_y     <= g_y;
        out_z     <= g_z;
      end
    end
  end

endmodule
